// File: rtl/ni_packetizer_pkg.sv
// ni_packetizer_pkg: mesh geometry, flit/FSM types and head-flit field helpers
package ni_packetizer_pkg;

    localparam int MESH_WIDTH  = 3;
    localparam int MESH_HEIGHT = 3;
    localparam int MESH_DEPTH  = 3;
    localparam int XW    = $clog2(MESH_WIDTH);
    localparam int YW    = $clog2(MESH_HEIGHT);
    localparam int ZW    = $clog2(MESH_DEPTH);
    localparam int POS_W = XW + YW + ZW;

    typedef struct packed {
        logic [ZW-1:0] z;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } position_t;

    typedef enum logic [1:0] {
        FT_BODY      = 2'd0,
        FT_HEAD      = 2'd1,
        FT_TAIL      = 2'd2,
        FT_HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } state_t;

    // Route field of a head flit: dest in the low POS_W bits, source above it.
    function automatic logic [2*POS_W-1:0] pack_route(position_t dest, position_t src);
        return {src, dest};
    endfunction

    function automatic position_t route_dest(logic [2*POS_W-1:0] r);
        return r[POS_W-1:0];
    endfunction

    function automatic position_t route_src(logic [2*POS_W-1:0] r);
        return r[2*POS_W-1:POS_W];
    endfunction

    function automatic logic pos_in_range(position_t p);
        return (32'(p.x) < MESH_WIDTH) && (32'(p.y) < MESH_HEIGHT) && (32'(p.z) < MESH_DEPTH);
    endfunction

endpackage

// File: rtl/ni_packetizer_credit_counter.sv
// credit_counter: saturating credit count with nonzero flag and sticky overflow
module credit_counter #(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o,
    output logic          ovf_o
);

    logic [CW-1:0] count_q;
    logic          ovf_q;

    // A return while already full saturates and latches overflow; inc+dec cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CW'(CREDITS);
            ovf_q   <= 1'b0;
        end else if (inc_i && !dec_i) begin
            if (count_q == CW'(CREDITS)) ovf_q <= 1'b1;
            else count_q <= count_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = count_q != '0;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns local message requests into credit-gated head/body/tail flits
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter  int PAYLOAD_W = 32,
    parameter  int MAX_LEN   = 8,
    parameter  int CREDITS   = 4,
    localparam int LEN_W     = $clog2(MAX_LEN + 1),
    localparam int FLIT_W    = PAYLOAD_W + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  position_t            my_pos,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  position_t            req_dest,
    input  logic [LEN_W-1:0]     req_len,
    input  logic                 pld_valid,
    output logic                 pld_ready,
    input  logic [PAYLOAD_W-1:0] pld_data,
    output logic                 flit_valid,
    output logic [FLIT_W-1:0]    flit_data,
    input  logic                 credit_in,
    output logic                 err_dest,
    output logic                 err_credit_ovf
);

    localparam int CW = $clog2(CREDITS + 1);

    state_t                state_q;
    position_t             dest_q;
    logic [LEN_W-1:0]      len_q, rem_q;
    logic                  flit_valid_q, err_dest_q, live_q;
    logic [FLIT_W-1:0]     flit_data_q;
    logic [CW-1:0]         cr_count;
    logic                  cr_nz, issue, req_ok;
    logic [PAYLOAD_W-1:0]  head_data;

    credit_counter #(.CREDITS(CREDITS)) u_credits (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (credit_in),
        .dec_i    (issue),
        .count_o  (cr_count),
        .nonzero_o(cr_nz),
        .ovf_o    (err_credit_ovf)
    );

    // live_q keeps req_ready low while reset is asserted even though the FSM sits in IDLE.
    assign req_ready = live_q && state_q == S_IDLE;
    assign pld_ready = state_q == S_BODY && cr_nz;
    assign issue     = cr_nz && (state_q == S_HEAD || (state_q == S_BODY && pld_valid));
    assign req_ok    = pos_in_range(req_dest) && req_len <= LEN_W'(MAX_LEN);
    assign head_data = PAYLOAD_W'({len_q, pack_route(dest_q, my_pos)});

    // Request/head/body sequencing with registered flit and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dest_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
            err_dest_q   <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            live_q       <= 1'b1;
            flit_valid_q <= issue;
            err_dest_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (req_valid && req_ready) begin
                    dest_q <= req_dest;
                    len_q  <= req_len;
                    rem_q  <= req_len;
                    if (req_ok) state_q <= S_HEAD;
                    else err_dest_q <= 1'b1;
                end
                S_HEAD: if (cr_nz) begin
                    flit_data_q <= {(len_q == '0) ? FT_HEAD_TAIL : FT_HEAD, head_data};
                    state_q     <= (len_q == '0) ? S_IDLE : S_BODY;
                end
                S_BODY: if (issue) begin
                    flit_data_q <= {(rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY, pld_data};
                    rem_q       <= rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_data  = flit_data_q;
    assign err_dest   = err_dest_q;

    // The flag and the count come from the same register and must always agree.
    a_cr_nz: assert property (@(posedge clk) disable iff (!rst_n) cr_nz == (cr_count != '0));

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: scoreboard bench with random traffic and a packet-level reference model
module tb_ni_packetizer;
    import ni_packetizer_pkg::*;

    localparam int PW = 32;
    localparam int ML = 8;
    localparam int CR = 4;
    localparam int LW = $clog2(ML + 1);
    localparam int FW = PW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    position_t my_pos = '0;
    position_t req_dest = '0;
    logic req_valid = 1'b0, req_ready, pld_valid = 1'b0, pld_ready;
    logic flit_valid, credit_in = 1'b0, err_dest, err_credit_ovf;
    logic [LW-1:0] req_len = '0;
    logic [PW-1:0] pld_data = '0;
    logic [FW-1:0] flit_data;

    always #5 clk = ~clk;

    ni_packetizer #(.PAYLOAD_W(PW), .MAX_LEN(ML), .CREDITS(CR)) dut (
        .clk(clk), .rst_n(rst_n), .my_pos(my_pos),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest), .req_len(req_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .flit_valid(flit_valid), .flit_data(flit_data), .credit_in(credit_in),
        .err_dest(err_dest), .err_credit_ovf(err_credit_ovf)
    );

    typedef struct { logic [FW-1:0] f; int at; } exp_t;
    exp_t exq[$];
    exp_t e_m;
    logic [PW-1:0] pq[$];
    logic [PW-1:0] side_q[$];
    int auto_due[$];
    int total = 0, bad = 0, cyc = 0, seen = 0, csent = 0, err_seen = 0, err_exp = 0, cr_req = 0;
    bit auto_cr = 1'b1, gaps = 1'b0, took = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic position_t pos(input int x, input int y, input int z);
        position_t p;
        p.x = XW'(x);
        p.y = YW'(y);
        p.z = ZW'(z);
        return p;
    endfunction

    // Monitor: every presented flit is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (err_dest) err_seen++;
        if (flit_valid) begin
            seen++;
            if (auto_cr) auto_due.push_back(cyc + 2);
            if (exq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit got=%0h want=none (cycle %0d)", flit_data, cyc);
            end else begin
                e_m = exq.pop_front();
                chk("flit", flit_data, e_m.f);
                if (e_m.at >= 0) chk("head_latency", cyc, e_m.at);
            end
        end
    end

    // Driver: payload words from pq, credit returns (scheduled or manual).
    always @(negedge clk) begin
        if (took) void'(pq.pop_front());
        pld_valid = pq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
        pld_data  = pq.size() > 0 ? pq[0] : '0;
        took      = pld_valid && pld_ready;
        credit_in = 1'b0;
        if (auto_due.size() > 0 && auto_due[0] <= cyc) begin
            void'(auto_due.pop_front());
            credit_in = 1'b1;
            csent++;
        end else if (cr_req > 0) begin
            cr_req--;
            credit_in = 1'b1;
            csent++;
        end
    end

    // Issues a request and pushes the whole expected packet (or an expected error).
    task automatic send(input position_t d, input int len, input logic [PW-1:0] base,
                        input bit lat, input bit side);
        int k, hd;
        logic [PW-1:0] w;
        exp_t e;
        bit ok;
        k = 0;
        while (!req_ready && k < 300) begin step(); k++; end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout got=0 want=1 (cycle %0d)", cyc);
            return;
        end
        req_valid = 1'b1;
        req_dest  = d;
        req_len   = LW'(len);
        ok = d.x < MESH_WIDTH && d.y < MESH_HEIGHT && d.z < MESH_DEPTH && len <= ML;
        if (ok) begin
            hd = d.x + d.y * (2 ** XW) + d.z * (2 ** (XW + YW))
               + my_pos.x * (2 ** POS_W) + my_pos.y * (2 ** (POS_W + XW))
               + my_pos.z * (2 ** (POS_W + XW + YW)) + len * (2 ** (2 * POS_W));
            e.f  = {(len == 0) ? 2'd3 : 2'd1, PW'(hd)};
            e.at = lat ? cyc + 2 : -1;
            exq.push_back(e);
            for (int i = 0; i < len; i++) begin
                w = (base != 0) ? base + PW'(i) : PW'($urandom);
                if (side) side_q.push_back(w);
                else pq.push_back(w);
                e.f  = {(i == len - 1) ? 2'd2 : 2'd0, w};
                e.at = -1;
                exq.push_back(e);
            end
        end else err_exp++;
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exq.size() > 0 && k < 2000) begin step(); k++; end
        if (exq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d want=0 pending flits", exq.size());
        end
        step(6);
    endtask

    task automatic restore();
        step(4);
        cr_req = seen - csent;
        step(cr_req + 4);
    endtask

    int s0;
    position_t rd;
    int rl;

    initial begin
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pld_ready", pld_ready, 0);
        chk("rst_flit_valid", flit_valid, 0);
        chk("rst_flit_data", flit_data, 0);
        chk("rst_err_dest", err_dest, 0);
        chk("rst_err_ovf", err_credit_ovf, 0);
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("idle_req_ready", req_ready, 1);

        // Basic 3-word packet with credits returned two cycles after each flit.
        send(pos(2, 1, 2), 3, 32'hA, 1'b1, 1'b0);
        drain();
        chk("basic_no_err", err_seen, 0);

        // Zero-length packet: single HEAD_TAIL, back to IDLE two cycles later.
        send(pos(1, 1, 1), 0, 0, 1'b1, 1'b0);
        chk("ht_busy", req_ready, 0);
        step();
        chk("ht_idle", req_ready, 1);
        drain();

        // No credit returns: only CREDITS flits, then two more per two credits.
        auto_cr = 1'b0;
        s0 = seen;
        send(pos(0, 2, 1), 7, 0, 1'b1, 1'b0);
        step(15);
        chk("stall_flits", seen - s0, 4);
        chk("stall_pld_ready", pld_ready, 0);
        cr_req = 2;
        step(10);
        chk("two_more_flits", seen - s0, 6);
        cr_req = 2;
        step(10);
        chk("stall_done", seen - s0, 8);
        restore();
        auto_cr = 1'b1;

        // Out-of-range destination and over-length request are dropped.
        s0 = seen;
        err_seen = 0;
        err_exp = 0;
        send(pos(3, 0, 0), 2, 0, 1'b0, 1'b0);
        send(pos(1, 1, 1), 9, 0, 1'b0, 1'b0);
        step(4);
        chk("err_dest_count", err_seen, 2);
        chk("err_no_flit", seen - s0, 0);

        // Credit return while full sets the sticky overflow.
        chk("ovf_clear", err_credit_ovf, 0);
        cr_req = 1;
        step(3);
        chk("ovf_set", err_credit_ovf, 1);
        step(5);
        chk("ovf_sticky", err_credit_ovf, 1);

        // Simultaneous issue and credit return at credits=2 keeps the count at 2.
        auto_cr = 1'b0;
        s0 = seen;
        send(pos(2, 2, 2), 7, 0, 1'b0, 1'b1);
        step(4);
        pq.push_back(side_q.pop_front());
        step(4);
        chk("sim_pre", seen - s0, 2);
        pq.push_back(side_q.pop_front());
        cr_req = 1;
        step();
        while (side_q.size() > 0) pq.push_back(side_q.pop_front());
        step(12);
        chk("sim_flits", seen - s0, 5);
        chk("sim_pld_ready", pld_ready, 0);
        cr_req = 3;
        step(10);
        chk("sim_done", seen - s0, 8);
        restore();
        auto_cr = 1'b1;

        // Randomized traffic with payload gaps and varying source position.
        gaps = 1'b1;
        err_seen = 0;
        err_exp = 0;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 300 && !req_ready; k++) step();
            my_pos = pos($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            rd = pos($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) rd.y = YW'(3);
            rl = ($urandom_range(0, 9) == 0) ? $urandom_range(ML + 1, 15) : $urandom_range(0, ML);
            send(rd, rl, 0, 1'b0, 1'b0);
        end
        drain();
        chk("rand_err_count", err_seen, err_exp);
        gaps = 1'b0;

        // Reset in the middle of a body stream.
        my_pos = pos(1, 0, 2);
        send(pos(0, 1, 2), 8, 0, 1'b0, 1'b0);
        for (int k = 0; k < 50 && !(flit_valid && pld_ready); k++) step();
        chk("pre_rst_streaming", flit_valid && pld_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flit_valid", flit_valid, 0);
        chk("mid_rst_pld_ready", pld_ready, 0);
        chk("mid_rst_ovf", err_credit_ovf, 0);
        exq.delete();
        pq.delete();
        auto_due.delete();
        took = 1'b0;
        cr_req = 0;
        auto_cr = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        s0 = seen;
        send(pos(2, 0, 1), 1, 32'h55, 1'b1, 1'b0);
        send(pos(1, 2, 0), 1, 32'h77, 1'b1, 1'b0);
        step(6);
        chk("post_rst_flits", seen - s0, 4);
        send(pos(0, 0, 0), 0, 0, 1'b0, 1'b0);
        step(6);
        chk("post_rst_no_credit", seen - s0, 4);
        cr_req = 1;
        step(6);
        chk("post_rst_last", seen - s0, 5);
        chk("post_rst_pending", exq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
